// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer.
// Holds the FSM state encoding, quarter-phase names and frame-length arithmetic.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int START_QTRS = 3;
    localparam int BYTE_QTRS  = 36;
    localparam int STOP_QTRS  = 3;
    localparam int GAP_QTRS   = 4;

    // Quarters in one complete write frame, inter-frame gap included.
    function automatic int frame_quarters(input int data_bytes);
        return START_QTRS + BYTE_QTRS * (1 + data_bytes) + STOP_QTRS + GAP_QTRS;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: tick is high on the last cycle of every CLK_DIV-cycle quarter.
// clr restarts the count so a new frame begins on a full quarter.
module i2c_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            DIV_ONE  = (CLK_DIV == 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Quarter counter; tick_r is registered one step ahead so it coincides with cnt_r == CNT_LAST.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= DIV_ONE;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= DIV_ONE;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            tick_r <= ((cnt_r + CNT_ONE) == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Walks an external table of NUM_CMDS register writes, sending each as one I2C write frame
// with ACK checking, bounded retry on NACK, and done/error reporting.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int         NUM_CMDS   = 7,
    parameter int         DATA_BYTES = 2,
    parameter int         CLK_DIV    = 1,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         MAX_RETRY  = 3,
    localparam int        IDX_W      = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic [IDX_W-1:0]        o_cmd_idx,
    input  logic [8*DATA_BYTES-1:0] i_cmd_data,
    input  logic                    i_sda,
    output logic                    o_sclk,
    output logic                    o_sdat,
    output logic                    o_oen,
    output logic                    o_busy,
    output logic                    o_finished,
    output logic                    o_error,
    output logic [IDX_W-1:0]        o_err_idx
);

    localparam int                 FRAME_W     = 8 * (DATA_BYTES + 1);
    localparam int                 RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_CMDS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE     = IDX_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
    localparam logic [2:0]         LAST_BYTE   = 3'(DATA_BYTES);

    state_t               state_r;
    logic [1:0]           qtr_r;
    logic [2:0]           bit_r;
    logic [2:0]           byte_r;
    logic [FRAME_W-1:0]   shift_r;
    logic [IDX_W-1:0]     idx_r;
    logic [RETRY_W-1:0]   retry_r;
    logic                 nack_r;
    logic                 sclk_r;
    logic                 sdat_r;
    logic                 oen_r;
    logic                 busy_r;
    logic                 fin_r;
    logic                 err_r;
    logic [IDX_W-1:0]     err_idx_r;

    logic                 tick_s;
    logic                 accept_s;
    logic [FRAME_W-1:0]   frame_s;

    // Address byte (write direction) followed by the payload, MSB byte first.
    assign frame_s  = {DEV_ADDR, 1'b0, i_cmd_data};
    assign accept_s = i_start && !busy_r;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (accept_s),
        .tick (tick_s)
    );

    // Frame sequencer: every bus line is a register updated only on quarter ticks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            qtr_r     <= Q0;
            bit_r     <= 3'd0;
            byte_r    <= 3'd0;
            shift_r   <= {FRAME_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            retry_r   <= {RETRY_W{1'b0}};
            nack_r    <= 1'b0;
            sclk_r    <= 1'b1;
            sdat_r    <= 1'b1;
            oen_r     <= 1'b1;
            busy_r    <= 1'b0;
            fin_r     <= 1'b0;
            err_r     <= 1'b0;
            err_idx_r <= {IDX_W{1'b0}};
        end else begin
            fin_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    sclk_r <= 1'b1;
                    sdat_r <= 1'b1;
                    oen_r  <= 1'b1;
                    if (accept_s) begin
                        state_r <= ST_START;
                        qtr_r   <= Q0;
                        idx_r   <= {IDX_W{1'b0}};
                        retry_r <= {RETRY_W{1'b0}};
                        nack_r  <= 1'b0;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_START: begin
                    if (tick_s) begin
                        case (qtr_r)
                            Q0: begin
                                qtr_r  <= Q1;
                                sdat_r <= 1'b0;
                            end
                            Q1: begin
                                qtr_r  <= Q2;
                                sclk_r <= 1'b0;
                            end
                            default: begin
                                state_r <= ST_BIT;
                                qtr_r   <= Q0;
                                bit_r   <= 3'd0;
                                byte_r  <= 3'd0;
                                sdat_r  <= frame_s[FRAME_W-1];
                                shift_r <= {frame_s[FRAME_W-2:0], 1'b0};
                            end
                        endcase
                    end
                end

                ST_BIT: begin
                    if (tick_s) begin
                        case (qtr_r)
                            Q0: qtr_r <= Q1;
                            Q1: begin
                                qtr_r  <= Q2;
                                sclk_r <= 1'b1;
                            end
                            Q2: qtr_r <= Q3;
                            default: begin
                                qtr_r  <= Q0;
                                sclk_r <= 1'b0;
                                if (bit_r == 3'd7) begin
                                    // Release SDA on the same edge that drops SCL.
                                    state_r <= ST_ACK;
                                    oen_r   <= 1'b0;
                                    sdat_r  <= 1'b1;
                                end else begin
                                    bit_r   <= bit_r + 3'd1;
                                    sdat_r  <= shift_r[FRAME_W-1];
                                    shift_r <= {shift_r[FRAME_W-2:0], 1'b0};
                                end
                            end
                        endcase
                    end
                end

                ST_ACK: begin
                    if (tick_s) begin
                        case (qtr_r)
                            Q0: qtr_r <= Q1;
                            Q1: begin
                                qtr_r  <= Q2;
                                sclk_r <= 1'b1;
                            end
                            Q2: begin
                                qtr_r  <= Q3;
                                nack_r <= i_sda;
                            end
                            default: begin
                                qtr_r  <= Q0;
                                sclk_r <= 1'b0;
                                oen_r  <= 1'b1;
                                if (nack_r || (byte_r == LAST_BYTE)) begin
                                    state_r <= ST_STOP;
                                    sdat_r  <= 1'b0;
                                end else begin
                                    state_r <= ST_BIT;
                                    byte_r  <= byte_r + 3'd1;
                                    bit_r   <= 3'd0;
                                    sdat_r  <= shift_r[FRAME_W-1];
                                    shift_r <= {shift_r[FRAME_W-2:0], 1'b0};
                                end
                            end
                        endcase
                    end
                end

                ST_STOP: begin
                    if (tick_s) begin
                        case (qtr_r)
                            Q0: begin
                                qtr_r  <= Q1;
                                sclk_r <= 1'b1;
                            end
                            Q1: begin
                                qtr_r  <= Q2;
                                sdat_r <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_GAP;
                                qtr_r   <= Q0;
                            end
                        endcase
                    end
                end

                ST_GAP: begin
                    if (tick_s) begin
                        if (qtr_r != Q3) begin
                            qtr_r <= qtr_r + 2'd1;
                        end else begin
                            qtr_r <= Q0;
                            if (nack_r && (retry_r < RETRY_LIMIT)) begin
                                retry_r <= retry_r + RETRY_ONE;
                                nack_r  <= 1'b0;
                                state_r <= ST_START;
                            end else if (nack_r) begin
                                state_r   <= ST_ERR;
                                err_r     <= 1'b1;
                                err_idx_r <= idx_r;
                                busy_r    <= 1'b0;
                            end else if (idx_r == LAST_IDX) begin
                                state_r <= ST_DONE;
                                fin_r   <= 1'b1;
                                busy_r  <= 1'b0;
                            end else begin
                                idx_r   <= idx_r + IDX_ONE;
                                retry_r <= {RETRY_W{1'b0}};
                                state_r <= ST_START;
                            end
                        end
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    sclk_r  <= 1'b1;
                    sdat_r  <= 1'b1;
                    oen_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_idx  = idx_r;
    assign o_sclk     = sclk_r;
    assign o_sdat     = sdat_r;
    assign o_oen      = oen_r;
    assign o_busy     = busy_r;
    assign o_finished = fin_r;
    assign o_error    = err_r;
    assign o_err_idx  = err_idx_r;

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Parametrised successor to the fixed WM8731 I2C init block.
- Walks a table of NUM_CMDS register-write commands and sends each as one I2C write frame: START, address byte, DATA_BYTES data bytes, STOP.
- Checks every slave ACK, retries NACKed frames, then reports completion or error.
- Sits between top-level init control and the codec/peripheral I2C pins.
- The command table stays external and is indexed through o_cmd_idx, so any ROM or register file can feed it.

Parameters:
NUM_CMDS, 7, number of commands in the table (>=1).
DATA_BYTES, 2, bytes sent after the address byte in each frame (1..4).
CLK_DIV, 1, i_clk cycles per SCL quarter-period (>=1).
DEV_ADDR, 7'h1A, 7-bit slave address; the R/W bit is always 0.
MAX_RETRY, 3, extra attempts per command after a NACK.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  start pulse; ignored while o_busy=1
o_cmd_idx  out  $clog2(NUM_CMDS)  current command index
i_cmd_data  in  8*DATA_BYTES  command payload for o_cmd_idx; MSB byte is sent first; must be valid combinationally
i_sda  in  1  sampled SDA line, used for ACK
o_sclk  out  1  SCL
o_sdat  out  1  SDA drive value
o_oen  out  1  1 = drive SDA, 0 = release SDA (ACK slot)
o_busy  out  1  high from the cycle after accepted i_start until DONE/ERR
o_finished  out  1  one-cycle pulse when all commands are ACKed
o_error  out  1  sticky error flag; cleared on the next accepted i_start
o_err_idx  out  $clog2(NUM_CMDS)  index of the failing command

Behaviour:
- Reset values: o_sclk=1, o_sdat=1, o_oen=1, o_busy=0, o_finished=0, o_error=0, o_err_idx=0, o_cmd_idx=0, state=IDLE.
- Reset is honoured mid-frame on the next edge. Lines jump high, which may look like a STOP; this is accepted.
- Tick: a quarter counter wraps every CLK_DIV cycles. All bus transitions occur only on ticks.
- States:
  - IDLE: lines high. i_start → START; clears o_error, idx=0, retry=0.
  - START: q0 SDA=1/SCL=1, q1 SDA=0, q2 SCL=0 → BIT.
  - BIT: byte 0 = {DEV_ADDR,1'b0}, then i_cmd_data bytes, MSB first. Per bit: q0 SCL=0 and SDA=bit, q1 hold, q2 SCL=1, q3 hold. After 8 bits → ACK.
  - ACK: o_oen=0 for all 4 quarters; SCL as for a bit. i_sda is sampled on the last cycle of q2.
    - ACK (0) with more bytes left → BIT.
    - ACK on the last byte → STOP.
    - NACK (1) → STOP with nack flag set.
  - STOP: q0 SCL=0/SDA=0, q1 SCL=1, q2 SDA=1 → GAP.
  - GAP: 4 quarters with lines high. Then:
    - nack and retry<MAX_RETRY: retry++, same idx → START.
    - nack and retries exhausted → ERR.
    - else if idx==NUM_CMDS-1 → DONE.
    - else idx++, retry=0 → START.
  - DONE: o_finished=1 for one cycle → IDLE.
  - ERR: o_error=1 and o_err_idx=idx, both held; → IDLE. o_finished is not pulsed.
- o_oen changes in the same cycle as the q0 SCL fall, so SDA is never driven while SCL is high in the ACK slot.
- Frame length in quarters: 3 + 36*(1+DATA_BYTES) + 3 + 4. With defaults this is 118 quarters = 118 cycles.
- i_start asserted together with i_rst is ignored. i_start pulses during busy are dropped, not queued.

Decomposition:
- Package i2c_pkg: state enum, quarter-phase constants, and a function giving the frame quarter-count.
- Sub-module i2c_tick_gen (CLK_DIV counter producing the tick pulse) is natural. Everything else stays in one FSM module.

Test Plan:
- Defaults, all ACK (i_sda=0 in ACK slots), i_start pulse → 7 frames, each with byte sequence 0x34, hi, lo. o_finished pulses exactly once at cycle 7*118+small constant. o_error=0.
- NACK on the address of idx 2, twice, then ACK → idx 2 is sent 3 times, sequence completes, o_error=0.
- Persistent NACK on the second data byte of idx 4 → 4 attempts (1+MAX_RETRY), o_error=1, o_err_idx=4, no o_finished, idx 5 never sent.
- CLK_DIV=4, DATA_BYTES=1 → each quarter lasts 4 cycles. Frame = 4*(3+72+3+4) = 328 cycles. SDA is stable whenever SCL=1, except at START/STOP.
- Assert i_rst at the middle of bit 5 of idx 1 → next cycle o_sclk=1, o_sdat=1, o_oen=1, o_busy=0. A fresh i_start restarts from idx 0.
- Extra i_start pulses while busy, and i_start together with i_rst → no change to sequencing, count stays 7 frames.
